// File: rtl/usb_buf_sched_pkg.sv
// Shared types and default widths for the endpoint buffer scheduler.
package usb_buf_sched_pkg;

  localparam int unsigned DEF_MAX_PKT = 512;
  localparam int unsigned DEF_ADDR_W  = 9;
  localparam int unsigned DEF_LEN_W   = 10;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {InIdle, InFill, InCommit, InWait} in_state_t;

  typedef enum logic [2:0] {OutIdle, OutRd, OutCap, OutPres, OutArm} out_state_t;

endpackage

// File: rtl/usb_buf_sched_if.sv
// Packet-buffer port, requester streams and sink stream of the buffer scheduler.
interface usb_buf_sched_if
  import usb_buf_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) ();

  logic [1:0]        req_valid;
  byte_t [1:0]       req_data;
  logic [1:0]        req_last;
  logic [1:0]        req_ready;
  logic              grant_id;

  logic [ADDR_W-1:0] buf_in_addr;
  byte_t             buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;

  logic [ADDR_W-1:0] buf_out_addr;
  byte_t             buf_out_q;
  logic [LEN_W-1:0]  buf_out_len;
  logic              buf_out_hasdata;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;

  logic              out_valid;
  byte_t             out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  req_valid, req_data, req_last,
    output req_ready, grant_id,
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_in_ready, buf_in_commit_ack,
    output buf_out_addr, buf_out_arm,
    input  buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    output req_valid, req_data, req_last,
    input  req_ready, grant_id,
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_in_ready, buf_in_commit_ack,
    input  buf_out_addr, buf_out_arm,
    output buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/usb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the owner once its packet is acked.
module usb_rr_arb2 (
  input  logic       phy_ulpi_clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       done_id,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic ptr_q;

  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~done_id;
    end
  end

  // Preferred requester wins; an idle preferred requester never blocks the other.
  always_comb begin
    gnt_id = req[ptr_q] ? ptr_q : ~ptr_q;
    grant  = '0;
    if (|req) begin
      grant[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/usb_buf_sched.sv
// Endpoint buffer scheduler: fills/commits IN packets from two requesters and drains OUT
// packets to a byte sink, then re-arms the OUT buffer.
module usb_buf_sched
  import usb_buf_sched_pkg::*;
#(
  parameter int unsigned MAX_PKT = DEF_MAX_PKT,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LEN_W   = DEF_LEN_W
) (
  input logic             phy_ulpi_clk,
  input logic             reset,
  input logic             stat_configured,
  usb_buf_sched_if.master bus
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_PKT);

  in_state_t        in_state_q, in_state_d;
  logic             grant_q, grant_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;

  out_state_t       out_state_q, out_state_d;
  logic [LEN_W-1:0] len_q, len_d, len_in;
  logic [LEN_W-1:0] idx_q, idx_d;
  byte_t            odata_q, odata_d;

  logic [1:0]       arb_grant;
  logic             arb_id;
  logic             arb_advance;

  usb_rr_arb2 u_arb (
    .phy_ulpi_clk(phy_ulpi_clk),
    .reset       (reset),
    .req         (bus.req_valid),
    .advance     (arb_advance),
    .done_id     (grant_q),
    .grant       (arb_grant),
    .gnt_id      (arb_id)
  );

  assign bus.grant_id          = grant_q;
  assign bus.buf_in_addr       = cnt_q[ADDR_W-1:0];
  assign bus.buf_in_commit_len = cnt_q;
  assign bus.buf_out_addr      = idx_q[ADDR_W-1:0];
  assign bus.out_data          = odata_q;

  always_comb begin
    in_state_d        = in_state_q;
    grant_d           = grant_q;
    cnt_d             = cnt_q;
    cnt_inc           = cnt_q + LEN_W'(1);
    bus.req_ready     = '0;
    bus.buf_in_wren   = 1'b0;
    bus.buf_in_data   = '0;
    bus.buf_in_commit = 1'b0;
    arb_advance       = 1'b0;
    unique case (in_state_q)
      InIdle: begin
        if (stat_configured && bus.buf_in_ready && (|arb_grant)) begin
          grant_d    = arb_id;
          cnt_d      = '0;
          in_state_d = InFill;
        end
      end
      InFill: begin
        bus.req_ready[grant_q] = 1'b1;
        if (bus.req_valid[grant_q]) begin
          bus.buf_in_wren = 1'b1;
          bus.buf_in_data = bus.req_data[grant_q];
          cnt_d           = cnt_inc;
          // A full buffer closes the packet even without a last marker.
          if (bus.req_last[grant_q] || (cnt_inc == MaxLen)) begin
            in_state_d = InCommit;
          end
        end
      end
      InCommit: begin
        bus.buf_in_commit = 1'b1;
        in_state_d        = InWait;
      end
      InWait: begin
        if (bus.buf_in_commit_ack) begin
          arb_advance = 1'b1;
          in_state_d  = InIdle;
        end
      end
      default: in_state_d = InIdle;
    endcase
    // Losing configuration drops the partial packet; the rr pointer is left alone.
    if (!stat_configured) begin
      in_state_d        = InIdle;
      cnt_d             = cnt_q;
      bus.req_ready     = '0;
      bus.buf_in_wren   = 1'b0;
      bus.buf_in_data   = '0;
      bus.buf_in_commit = 1'b0;
      arb_advance       = 1'b0;
    end
  end

  always_comb begin
    out_state_d     = out_state_q;
    len_d           = len_q;
    idx_d           = idx_q;
    odata_d         = odata_q;
    len_in          = (bus.buf_out_len > MaxLen) ? MaxLen : bus.buf_out_len;
    bus.out_valid   = 1'b0;
    bus.out_last    = 1'b0;
    bus.buf_out_arm = 1'b0;
    unique case (out_state_q)
      OutIdle: begin
        if (stat_configured && bus.buf_out_hasdata) begin
          len_d       = len_in;
          idx_d       = '0;
          out_state_d = (len_in == '0) ? OutArm : OutRd;
        end
      end
      OutRd:  out_state_d = OutCap;
      OutCap: begin
        odata_d     = bus.buf_out_q;
        out_state_d = OutPres;
      end
      OutPres: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (idx_q == (len_q - LEN_W'(1)));
        if (bus.out_ready) begin
          idx_d       = idx_q + LEN_W'(1);
          out_state_d = bus.out_last ? OutArm : OutRd;
        end
      end
      OutArm: begin
        bus.buf_out_arm = 1'b1;
        if (bus.buf_out_arm_ack) begin
          out_state_d = OutIdle;
        end
      end
      default: out_state_d = OutIdle;
    endcase
    if (!stat_configured) begin
      out_state_d     = OutIdle;
      bus.out_valid   = 1'b0;
      bus.out_last    = 1'b0;
      bus.buf_out_arm = 1'b0;
    end
  end

  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      in_state_q  <= InIdle;
      grant_q     <= 1'b0;
      cnt_q       <= '0;
      out_state_q <= OutIdle;
      len_q       <= '0;
      idx_q       <= '0;
      odata_q     <= '0;
    end else begin
      in_state_q  <= in_state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_state_q <= out_state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      odata_q     <= odata_d;
    end
  end

endmodule

// File: tb/tb_usb_buf_sched.sv
// Bench for usb_buf_sched: packet-level model of both buffer directions plus directed cases.
module tb_usb_buf_sched;
  import usb_buf_sched_pkg::*;

  localparam int unsigned MAX_PKT = 512;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned LEN_W   = 10;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } item_t;

  logic phy_ulpi_clk = 1'b0;
  logic reset;
  logic stat_configured;

  always #5 phy_ulpi_clk = ~phy_ulpi_clk;

  usb_buf_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  usb_buf_sched #(.MAX_PKT(MAX_PKT), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .phy_ulpi_clk   (phy_ulpi_clk),
    .reset          (reset),
    .stat_configured(stat_configured),
    .bus            (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus and core-side state.
  item_t      txq [2][$];
  logic [7:0] omem [0:511];
  logic [8:0] last_rd_addr = '0;
  logic [1:0] hs = '0;
  logic       ob_has = 1'b0;
  logic [9:0] ob_len = '0;
  logic       rdy_toggle = 1'b0;
  int         cyc = 0;
  int         ack_cnt = 0;
  int         arm_cnt = 0;

  // Packet-level model state.
  int         m_off = 0;
  logic       m_end = 1'b0;
  int         m_owner = 0;
  logic       waiting = 1'b0;
  int         wait_len = 0;
  logic       commit_prev = 1'b0;
  logic       cfg_low_prev = 1'b0;
  item_t      exp_out[$];
  logic       ov_prev = 1'b0;
  logic       or_prev = 1'b0;
  logic [8:0] od_prev = '0;
  int         clog_owner[$];
  int         clog_len[$];
  logic [8:0] sink_log[$];
  int         arm_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    item_t it;
    it.d = d;
    it.l = l;
    txq[r].push_back(it);
  endtask

  task automatic load_out(input int len);
    item_t it;
    ob_len = 10'(len);
    for (int i = 0; i < len; i++) begin
      it.d = omem[i];
      it.l = (i == len - 1);
      exp_out.push_back(it);
    end
    ob_has = 1'b1;
  endtask

  task automatic compare();
    int r;
    if (!stat_configured) begin
      if (cfg_low_prev) begin
        check("idle_strobes", {bus.buf_in_wren, bus.buf_in_commit, bus.buf_out_arm,
                               bus.out_valid, bus.req_ready}, '0);
      end
      m_off = 0; m_end = 1'b0; waiting = 1'b0; ack_cnt = 0; arm_cnt = 0;
      exp_out.delete(); ob_has = 1'b0; ov_prev = 1'b0; commit_prev = 1'b0;
      txq[0].delete(); txq[1].delete(); hs = '0;
      cfg_low_prev = 1'b1;
      return;
    end
    cfg_low_prev = 1'b0;
    // IN direction: every accepted byte lands at the next offset of the owner's packet.
    if (hs != 2'b00) begin
      r = hs[1] ? 1 : 0;
      check("ready_onehot", $countones(bus.req_ready), 1);
      check("fill_when_free", {m_end, waiting}, 2'b00);
      if (m_off != 0) check("same_owner", r, m_owner);
      else m_owner = r;
      check("grant_id", bus.grant_id, r);
      check("wren", bus.buf_in_wren, 1'b1);
      check("wr_addr", bus.buf_in_addr, m_off);
      check("wr_data", bus.buf_in_data, txq[r][0].d);
      m_off++;
      if (txq[r][0].l || m_off == MAX_PKT) m_end = 1'b1;
    end else begin
      check("no_stray_wren", bus.buf_in_wren, 1'b0);
    end
    if (bus.buf_in_commit) begin
      check("commit_single", commit_prev, 1'b0);
      check("commit_after_end", m_end, 1'b1);
      check("commit_len", bus.buf_in_commit_len, m_off);
      clog_owner.push_back(m_owner);
      clog_len.push_back(int'(bus.buf_in_commit_len));
      wait_len = m_off; m_off = 0; m_end = 1'b0; waiting = 1'b1; ack_cnt = 3;
    end else if (waiting) begin
      check("commit_len_held", bus.buf_in_commit_len, wait_len);
      if (bus.buf_in_commit_ack) waiting = 1'b0;
    end
    commit_prev = bus.buf_in_commit;
    // OUT direction: sink sees the loaded bytes in order, last on the final one.
    if (bus.out_valid) begin
      if (ov_prev && !or_prev) check("out_hold", {bus.out_data, bus.out_last}, od_prev);
      check("out_expected", exp_out.size() != 0, 1'b1);
      if (bus.out_ready && exp_out.size() != 0) begin
        check("out_data", bus.out_data, exp_out[0].d);
        check("out_last", bus.out_last, exp_out[0].l);
        sink_log.push_back({bus.out_data, bus.out_last});
        void'(exp_out.pop_front());
      end
    end
    ov_prev = bus.out_valid;
    or_prev = bus.out_ready;
    od_prev = {bus.out_data, bus.out_last};
    if (bus.buf_out_arm) begin
      check("arm_after_drain", exp_out.size(), 0);
      check("arm_has_pkt", ob_has, 1'b1);
      if (bus.buf_out_arm_ack) begin
        arm_count++;
        ob_has = 1'b0;
      end else if (arm_cnt == 0) begin
        arm_cnt = 3;
      end
    end
  endtask

  // Drives all bus inputs on the falling edge, then samples and checks 1ns later.
  initial begin
    forever begin
      @(negedge phy_ulpi_clk);
      cyc++;
      for (int r = 0; r < 2; r++) begin
        if (hs[r] && txq[r].size() != 0) void'(txq[r].pop_front());
      end
      for (int r = 0; r < 2; r++) begin
        if (txq[r].size() != 0) begin
          bus.req_valid[r] = 1'b1;
          bus.req_data[r]  = txq[r][0].d;
          bus.req_last[r]  = txq[r][0].l;
        end else begin
          bus.req_valid[r] = 1'b0;
          bus.req_data[r]  = '0;
          bus.req_last[r]  = 1'b0;
        end
      end
      bus.buf_in_ready      = 1'b1;
      bus.buf_in_commit_ack = (ack_cnt == 1);
      if (ack_cnt > 0) ack_cnt--;
      bus.buf_out_arm_ack   = (arm_cnt == 1);
      if (arm_cnt > 0) arm_cnt--;
      bus.buf_out_hasdata   = ob_has;
      bus.buf_out_len       = ob_len;
      bus.out_ready         = rdy_toggle ? cyc[0] : 1'b1;
      bus.buf_out_q         = omem[last_rd_addr];
      #1;
      last_rd_addr = bus.buf_out_addr;
      hs = bus.req_valid & bus.req_ready;
      if (!reset) compare();
    end
  end

  task automatic wait_quiet(input string name);
    int n = 0;
    while (!(txq[0].size() == 0 && txq[1].size() == 0 && m_off == 0 && !m_end && !waiting &&
             exp_out.size() == 0 && !ob_has) && n < 4000) begin
      @(posedge phy_ulpi_clk);
      n++;
    end
    check({name, "_done"}, n < 4000, 1'b1);
    repeat (2) @(posedge phy_ulpi_clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    stat_configured = 1'b0;
    for (int i = 0; i < 512; i++) omem[i] = '0;
    repeat (3) @(posedge phy_ulpi_clk);
    #1;
    check("rst_wren", bus.buf_in_wren, 1'b0);
    check("rst_commit", bus.buf_in_commit, 1'b0);
    check("rst_commit_len", bus.buf_in_commit_len, 0);
    check("rst_grant", bus.grant_id, 1'b0);
    check("rst_ready", bus.req_ready, 2'b00);
    check("rst_arm", bus.buf_out_arm, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_addr", bus.buf_out_addr, 0);
    reset = 1'b0;
    stat_configured = 1'b1;
    repeat (2) @(posedge phy_ulpi_clk);

    // 1: requester 0, four bytes.
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b0); push(0, 8'h44, 1'b1);
    wait_quiet("t1");
    check("t1_count", clog_len.size(), 1);
    check("t1_len", clog_len[0], 4);
    check("t1_owner", clog_owner[0], 0);

    // 2: both requesters, two 2-byte packets each; pointer is at 1 after test 1.
    for (int p = 0; p < 2; p++) begin
      push(0, 8'hA0 + 8'(p), 1'b0); push(0, 8'hB0 + 8'(p), 1'b1);
      push(1, 8'hC0 + 8'(p), 1'b0); push(1, 8'hD0 + 8'(p), 1'b1);
    end
    wait_quiet("t2");
    check("t2_count", clog_len.size(), 5);
    for (int k = 0; k < 4; k++) begin
      check("t2_owner", clog_owner[1 + k], (k % 2 == 0) ? 1 : 0);
      check("t2_len", clog_len[1 + k], 2);
    end

    // 3: 600 bytes from requester 1 split at the buffer limit.
    for (int i = 0; i < 600; i++) push(1, 8'(i) ^ 8'h5A, (i == 599));
    wait_quiet("t3");
    check("t3_count", clog_len.size(), 7);
    check("t3_len_full", clog_len[5], 512);
    check("t3_len_rest", clog_len[6], 88);
    check("t3_owner", clog_owner[6], 1);

    // 4: OUT packet of three bytes with a stuttering sink.
    omem[0] = 8'hA1; omem[1] = 8'hB2; omem[2] = 8'hC3;
    rdy_toggle = 1'b1;
    load_out(3);
    wait_quiet("t4");
    rdy_toggle = 1'b0;
    check("t4_bytes", sink_log.size(), 3);
    check("t4_b0", sink_log[0], {8'hA1, 1'b0});
    check("t4_b1", sink_log[1], {8'hB2, 1'b0});
    check("t4_b2", sink_log[2], {8'hC3, 1'b1});
    check("t4_arms", arm_count, 1);

    // 5: empty OUT packet is re-armed without touching the sink.
    load_out(0);
    wait_quiet("t5");
    check("t5_bytes", sink_log.size(), 3);
    check("t5_arms", arm_count, 2);

    // 6: configuration lost with five IN bytes written and an OUT packet in flight.
    for (int i = 0; i < 10; i++) push(0, 8'h70 + 8'(i), (i == 9));
    for (int i = 0; i < 8; i++) omem[i] = 8'h90 + 8'(i);
    load_out(8);
    n = 0;
    while (m_off != 5 && n < 200) begin
      @(posedge phy_ulpi_clk);
      n++;
    end
    check("t6_reach5", n < 200, 1'b1);
    #1;
    stat_configured = 1'b0;
    repeat (5) @(posedge phy_ulpi_clk);
    check("t6_no_commit", clog_len.size(), 7);
    check("t6_no_arm", arm_count, 2);
    check("t6_sink_partial", sink_log.size() < 11, 1'b1);
    #1;
    stat_configured = 1'b1;
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    wait_quiet("t6");
    check("t6_count", clog_len.size(), 8);
    check("t6_fresh_len", clog_len[7], 3);
    check("t6_arms", arm_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
